mem_arbiter: RTL

Two-requester memory arbiter between the pipelined core's instruction port (imem_*) and data port (dmem_*) and a single shared backing-memory port (mem_*). It captures one request per channel and serializes them onto the memory port, one transaction at a time. It routes each memory response back to the channel that issued it. It sits between the core and the unified cache/memory model.

---
 rtl/mem_arbiter.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Two-requester arbiter placing the core's instruction port (imem_*) and data
// port (dmem_*) onto one shared backing-memory port (mem_*). Each channel can
// hold one captured request. Requests go out one at a time, and each memory
// response is routed back to the channel that issued it.
//
// Ports
//   clk, rst_n               clock; synchronous active-low reset
//   imem_addr/rmask          fetch request (nonzero rmask for one cycle)
//   imem_rdata/resp          fetch data (= mem_rdata) and one-cycle completion
//   dmem_addr/rmask/wmask    load/store request (nonzero mask for one cycle)
//   dmem_wdata               store data
//   dmem_rdata/resp          load data (= mem_rdata) and one-cycle completion
//   mem_addr/wdata/rmask/wmask  shared-port request, valid for the grant cycle
//   mem_rdata/resp           shared-port read data and one-cycle completion
//   arb_busy                 a transaction is outstanding or a request is pending
//
// Build option
//   MEM_ARB_RR_EN  defined   : round-robin tie break, using last_grant
//                  undefined : fixed priority, dmem wins ties
// -----------------------------------------------------------------------------
module mem_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] imem_addr,
  input  logic [3:0]  imem_rmask,
  output logic [31:0] imem_rdata,
  output logic        imem_resp,
  input  logic [31:0] dmem_addr,
  input  logic [3:0]  dmem_rmask,
  input  logic [3:0]  dmem_wmask,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        dmem_resp,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_rmask,
  output logic [3:0]  mem_wmask,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp,
  output logic        arb_busy
);

  typedef enum logic [1:0] {IDLE, WAIT_I, WAIT_D} state_t;

  state_t      state_reg, state_next;
  logic        last_grant_reg;      // 0 = imem, 1 = dmem

  logic        i_pend_reg;
  logic [31:0] i_addr_reg;
  logic [3:0]  i_rmask_reg;

  logic        d_pend_reg;
  logic [31:0] d_addr_reg;
  logic [3:0]  d_rmask_reg;
  logic [3:0]  d_wmask_reg;
  logic [31:0] d_wdata_reg;

  logic        i_req, d_req;
  logic        i_cap, d_cap;
  logic        grant_i, grant_d;

  assign i_req = |imem_rmask;
  assign d_req = (|dmem_rmask) | (|dmem_wmask);

  // A channel is still occupied while its transaction waits for mem_resp.
  // In the cycle mem_resp arrives, the channel is free again, so a new request
  // presented alongside the resp is captured at that same edge.
  assign i_cap = i_req && !i_pend_reg && !(state_reg == WAIT_I && !mem_resp);
  assign d_cap = d_req && !d_pend_reg && !(state_reg == WAIT_D && !mem_resp);

  // Grant selection, only ever made from IDLE.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (state_reg == IDLE) begin
      if (i_pend_reg && d_pend_reg) begin
`ifdef MEM_ARB_RR_EN
        // Hand the port to whichever channel did not get it last time.
        if (last_grant_reg) grant_i = 1'b1;
        else                grant_d = 1'b1;
`else
        grant_d = 1'b1;
`endif
      end else if (i_pend_reg) begin
        grant_i = 1'b1;
      end else if (d_pend_reg) begin
        grant_d = 1'b1;
      end
    end
  end

`ifndef MEM_ARB_RR_EN
  // Fixed priority never reads the grant history; it is still tracked so the
  // register behaves the same way in both builds.
  logic unused_last_grant;
  assign unused_last_grant = last_grant_reg;
`endif

  // Next state and outputs.
  always_comb begin
    state_next = state_reg;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_rmask  = '0;
    mem_wmask  = '0;
    imem_resp  = 1'b0;
    dmem_resp  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (grant_i) begin
          mem_addr   = i_addr_reg;
          mem_rmask  = i_rmask_reg;
          state_next = WAIT_I;
        end else if (grant_d) begin
          mem_addr   = d_addr_reg;
          mem_wdata  = d_wdata_reg;
          mem_rmask  = d_rmask_reg;
          mem_wmask  = d_wmask_reg;
          state_next = WAIT_D;
        end
      end
      WAIT_I: begin
        if (mem_resp) begin
          imem_resp  = 1'b1;
          state_next = IDLE;
        end
      end
      WAIT_D: begin
        if (mem_resp) begin
          dmem_resp  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign imem_rdata = mem_rdata;
  assign dmem_rdata = mem_rdata;
  assign arb_busy   = (state_reg != IDLE) || i_pend_reg || d_pend_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b0;
      i_pend_reg     <= 1'b0;
      i_addr_reg     <= '0;
      i_rmask_reg    <= '0;
      d_pend_reg     <= 1'b0;
      d_addr_reg     <= '0;
      d_rmask_reg    <= '0;
      d_wmask_reg    <= '0;
      d_wdata_reg    <= '0;
    end else begin
      state_reg <= state_next;

      if (grant_i)      last_grant_reg <= 1'b0;
      else if (grant_d) last_grant_reg <= 1'b1;

      // Capture and grant never coincide on a channel: a grant needs the
      // pending bit set, and a capture needs it clear.
      if (i_cap) begin
        i_pend_reg  <= 1'b1;
        i_addr_reg  <= imem_addr;
        i_rmask_reg <= imem_rmask;
      end else if (grant_i) begin
        i_pend_reg  <= 1'b0;
      end

      if (d_cap) begin
        d_pend_reg  <= 1'b1;
        d_addr_reg  <= dmem_addr;
        d_rmask_reg <= dmem_rmask;
        d_wmask_reg <= dmem_wmask;
        d_wdata_reg <= dmem_wdata;
      end else if (grant_d) begin
        d_pend_reg  <= 1'b0;
      end
    end
  end

  // A request on a channel that is still occupied is dropped; flag it in
  // simulation because the requester has broken the handshake.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(i_req && !i_cap))
        else $error("mem_arbiter: imem request dropped, channel occupied");
      assert (!(d_req && !d_cap))
        else $error("mem_arbiter: dmem request dropped, channel occupied");
    end
  end

endmodule
